// File: rtl/hog_cell_scheduler.sv
// ---------------------------------------------------------------------------
// hog_cell_scheduler
//
// Frame-level sequencer placed in front of hog_feature_gen. It accepts one
// 9-bin cell histogram per handshake, tags each cell with its linear raster
// address and forwards it to the feature generator. At frame start it issues
// a one-cycle clear (valid_fw with addr_fw==0). Block features returned by the
// generator (fea_valid) are counted. The frame completes when all
// (CELLS_X-1)*(CELLS_Y-1) blocks have arrived, or when the generator stays
// silent for DRAIN_TO cycles after the last cell, which sets a sticky error.
//
// Optional build macro: HOG_SCHED_GAP_EN
//   When defined, s_ready drops for MIN_GAP cycles after every accepted cell.
//   When undefined, cells may be accepted every cycle and MIN_GAP is ignored.
//
// Ports
//   clk, rst      clock; synchronous active-low reset
//   start         frame start pulse (honoured only in IDLE)
//   s_bin/s_valid/s_ready   incoming cell histogram stream, bin0 in LSBs
//   addr_fw/valid_fw        forward address strobe (clear in CLEAR state)
//   address/bin/i_valid     registered cell data to the feature generator
//   fea_valid     one pulse per block feature from the generator
//   busy          high in CLEAR, RUN and DRAIN
//   frame_done    one-cycle pulse at frame end (normal or timeout)
//   timeout_err   sticky drain-timeout flag, cleared by the next start
//   block_cnt     blocks received in the current frame (saturating)
// ---------------------------------------------------------------------------
module hog_cell_scheduler #(
  parameter int ADDR_W   = 11,
  parameter int BIN_W    = 32,
  parameter int CELLS_X  = 40,
  parameter int CELLS_Y  = 30,
  parameter int DRAIN_TO = 256,
  parameter int MIN_GAP  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [9*BIN_W-1:0]   s_bin,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [ADDR_W-1:0]    addr_fw,
  output logic                 valid_fw,
  output logic [ADDR_W-1:0]    address,
  output logic [9*BIN_W-1:0]   bin,
  output logic                 i_valid,
  input  logic                 fea_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 timeout_err,
  output logic [ADDR_W-1:0]    block_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int                IDLE_W       = $clog2(DRAIN_TO + 1);
  localparam logic [ADDR_W-1:0] LAST_CELL    = ADDR_W'(CELLS_X * CELLS_Y - 1);
  localparam logic [ADDR_W-1:0] BLOCK_TARGET = ADDR_W'((CELLS_X - 1) * (CELLS_Y - 1));
  // Compared against the count before the current cycle is added, so the
  // pulse lands exactly DRAIN_TO cycles after the last fea_valid.
  localparam logic [IDLE_W-1:0] IDLE_LAST    = IDLE_W'(DRAIN_TO - 1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   cell_idx;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [ADDR_W-1:0]   block_cnt_nxt;
  logic                accept;
  logic                gap_open;
  logic                cnt_en;
  logic                blocks_done;
  logic                drain_to_hit;
  logic                timeout_set;

  // -------------------------------------------------------------------------
  // Optional inter-cell gap
  // -------------------------------------------------------------------------
`ifdef HOG_SCHED_GAP_EN
  localparam int GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      gap_cnt <= '0;
    end else if (accept) begin
      gap_cnt <= GAP_W'(MIN_GAP);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  assign gap_open = (gap_cnt == '0);
`else
  // MIN_GAP is never negative, so this is constant-true: no throttling here.
  assign gap_open = (MIN_GAP >= 0);
`endif

  // -------------------------------------------------------------------------
  // Combinational handshake and counters
  // -------------------------------------------------------------------------
  assign s_ready  = (state == RUN) && gap_open;
  assign accept   = s_valid && s_ready;
  assign valid_fw = (state == CLEAR);
  assign addr_fw  = (state == CLEAR) ? '0 : address;
  assign busy     = (state != IDLE);

  // fea_valid is ignored in IDLE; the count saturates at all-ones.
  assign cnt_en        = fea_valid && (state != IDLE);
  assign block_cnt_nxt = (cnt_en && (block_cnt != '1)) ? block_cnt + 1'b1 : block_cnt;

  // Completion uses the updated count so a pulse arriving in the final cycle
  // is included in the frame.
  assign blocks_done  = (block_cnt_nxt >= BLOCK_TARGET);
  assign drain_to_hit = !fea_valid && (idle_cnt == IDLE_LAST);
  assign timeout_set  = (state == DRAIN) && !blocks_done && drain_to_hit;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is assigned a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (accept && (cell_idx == LAST_CELL)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (blocks_done || drain_to_hit) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state       <= IDLE;
      cell_idx    <= '0;
      address     <= '0;
      // NOTE: the wide bin register is reset too because its value is a
      // visible output that must read zero after reset.
      bin         <= '0;
      i_valid     <= 1'b0;
      block_cnt   <= '0;
      timeout_err <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      state   <= state_nxt;
      i_valid <= accept;

      if (accept) begin
        address  <= cell_idx;
        bin      <= s_bin;
        cell_idx <= cell_idx + 1'b1;
      end

      if ((state == IDLE) && start) begin
        block_cnt   <= '0;
        timeout_err <= 1'b0;
        cell_idx    <= '0;
      end else begin
        block_cnt <= block_cnt_nxt;
        if (timeout_set) timeout_err <= 1'b1;
      end

      // Silence counter: only meaningful in DRAIN, restarts on every block.
      if ((state == DRAIN) && !fea_valid) idle_cnt <= idle_cnt + 1'b1;
      else                                idle_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_hog_cell_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hog_cell_scheduler
//
// Small-frame bench (4x3 cells, DRAIN_TO=16). Random histograms are offered on
// the input stream; every handshake pushes the expected {address, bin} into a
// scoreboard queue, with addresses taken from a frame-level cell counter. A
// monitor pops and compares on each i_valid. A feature-generator model emits
// one fea_valid a fixed latency after every cell that completes a 2x2 block
// (column>0 and row>0), optionally capped to force a drain timeout.
// ---------------------------------------------------------------------------
module tb_hog_cell_scheduler;

  localparam int ADDR_W   = 11;
  localparam int BIN_W    = 32;
  localparam int CELLS_X  = 4;
  localparam int CELLS_Y  = 3;
  localparam int DRAIN_TO = 16;
`ifdef HOG_SCHED_GAP_EN
  localparam int MIN_GAP  = 2;
`else
  localparam int MIN_GAP  = 0;
`endif
  localparam int N_CELLS  = CELLS_X * CELLS_Y;
  localparam int N_BLOCKS = (CELLS_X - 1) * (CELLS_Y - 1);
  localparam int FEA_LAT  = 3;
  localparam int BUDGET   = 400;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [9*BIN_W-1:0]  s_bin = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [ADDR_W-1:0]   addr_fw;
  logic                valid_fw;
  logic [ADDR_W-1:0]   address;
  logic [9*BIN_W-1:0]  bin;
  logic                i_valid;
  logic                fea_valid = 1'b0;
  logic                busy;
  logic                frame_done;
  logic                timeout_err;
  logic [ADDR_W-1:0]   block_cnt;

  hog_cell_scheduler #(
    .ADDR_W   (ADDR_W),
    .BIN_W    (BIN_W),
    .CELLS_X  (CELLS_X),
    .CELLS_Y  (CELLS_Y),
    .DRAIN_TO (DRAIN_TO),
    .MIN_GAP  (MIN_GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_bin       (s_bin),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .addr_fw     (addr_fw),
    .valid_fw    (valid_fw),
    .address     (address),
    .bin         (bin),
    .i_valid     (i_valid),
    .fea_valid   (fea_valid),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .block_cnt   (block_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [9*BIN_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   fea_sched[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Frame-level model state
  int model_idx;
  int fea_sent;
  int fea_limit;
  int valid_fw_cnt;
  int ivalid_cnt;
  int done_cnt;
  int last_fea_cyc;
  int done_cyc;
  int clear_cyc;
  int first_iv_cyc;
  int last_iv_cyc;
  bit stim_en;
  bit hold_mode;
  bit start_at_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Input stream stimulus: always-valid or 50% bubbles, random bins.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      s_valid = stim_en && (hold_mode || ($urandom_range(0, 1) == 1));
      for (int b = 0; b < 9; b++) s_bin[b*BIN_W +: BIN_W] = BIN_W'($urandom());
    end
  end

  // Feature-generator model: replays scheduled block pulses, capped per frame.
  initial begin
    bit start_driven;
    start_driven = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (start_driven) begin
        start        = 1'b0;
        start_driven = 1'b0;
      end
      fea_valid = 1'b0;
      if (fea_sched.size() > 0 && fea_sched[0] <= cyc) begin
        void'(fea_sched.pop_front());
        if (fea_sent < fea_limit) begin
          fea_valid = 1'b1;
          fea_sent++;
          if (start_at_done && fea_sent == N_BLOCKS) begin
            start        = 1'b1;
            start_driven = 1'b1;
          end
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (s_valid && s_ready) begin
          exp_q.push_back('{addr: ADDR_W'(model_idx), data: s_bin});
          model_idx++;
        end
        if (valid_fw) begin
          valid_fw_cnt++;
          clear_cyc = cyc;
          check("addr_fw during clear", addr_fw, 0);
        end
        if (i_valid) begin
          if (exp_q.size() == 0) begin
            check("i_valid without accept (queue size)", exp_q.size(), 1);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("cell address", address, e.addr);
            check("cell bin", bin, e.data);
            if (int'(e.addr) % CELLS_X != 0 && int'(e.addr) / CELLS_X != 0)
              fea_sched.push_back(cyc + FEA_LAT);
          end
          if (hold_mode && last_iv_cyc >= 0)
            check("i_valid spacing", cyc - last_iv_cyc, MIN_GAP + 1);
          if (first_iv_cyc < 0) first_iv_cyc = cyc;
          last_iv_cyc = cyc;
          ivalid_cnt++;
        end
        if (fea_valid) last_fea_cyc = cyc;
        if (frame_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic prep_frame(input int limit, input bit hold, input bit sad);
    exp_q.delete();
    fea_sched.delete();
    model_idx     = 0;
    fea_sent      = 0;
    fea_limit     = limit;
    valid_fw_cnt  = 0;
    ivalid_cnt    = 0;
    done_cnt      = 0;
    last_fea_cyc  = -1;
    done_cyc      = -1;
    clear_cyc     = -1;
    first_iv_cyc  = -1;
    last_iv_cyc   = -1;
    hold_mode     = hold;
    start_at_done = sad;
  endtask

  task automatic run_frame(input int limit, input bit hold, input bit start_in_run,
                           input bit sad, input bit expect_to, input bit prev_to);
    int n;
    int exp_blocks;
    bit pulsed;
    logic [ADDR_W-1:0] bc_done;
    exp_blocks = (limit < N_BLOCKS) ? limit : N_BLOCKS;
    pulsed     = 1'b0;
    prep_frame(limit, hold, sad);
    check("timeout_err in IDLE before start", timeout_err, prev_to);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("valid_fw in CLEAR", valid_fw, 1);
    check("busy in CLEAR", busy, 1);
    check("timeout_err cleared by start", timeout_err, 0);
    stim_en = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < BUDGET) begin
      if (start_in_run && !pulsed && model_idx >= 4) begin
        start  = 1'b1;
        pulsed = 1'b1;
        tick();
        start  = 1'b0;
      end else begin
        tick();
      end
      n++;
    end
    stim_en = 1'b0;
    check("frame_done seen within budget", done_cnt > 0, 1);
    check("frame_done single pulse", frame_done, 0);
    check("busy after frame", busy, 0);
    check("block_cnt at frame end", block_cnt, exp_blocks);
    check("timeout_err at frame end", timeout_err, expect_to);
    check("cells accepted", model_idx, N_CELLS);
    check("i_valid count", ivalid_cnt, N_CELLS);
    check("scoreboard drained", exp_q.size(), 0);
    if (expect_to)
      check("timeout distance from last fea_valid", done_cyc - last_fea_cyc, DRAIN_TO);
    if (hold) begin
      check("first i_valid after clear", first_iv_cyc - clear_cyc, 2);
      check("accept span", last_iv_cyc - first_iv_cyc, (N_CELLS - 1) * (MIN_GAP + 1));
    end
    bc_done = block_cnt;
    tick(5);
    check("still idle after frame", busy, 0);
    check("single clear per frame", valid_fw_cnt, 1);
    check("single frame_done", done_cnt, 1);
    check("block_cnt holds in IDLE", block_cnt, bc_done);
  endtask

  task automatic reset_mid_frame();
    int n;
    prep_frame(N_BLOCKS, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start   = 1'b0;
    stim_en = 1'b1;
    n = 0;
    while (ivalid_cnt < 6 && n < BUDGET) begin
      tick();
      n++;
    end
    check("reached cell 5 before reset", ivalid_cnt >= 6, 1);
    stim_en = 1'b0;
    s_valid = 1'b0;
    rst     = 1'b0;
    tick();
    check("outputs zero after mid-frame reset",
          {s_ready, addr_fw, valid_fw, address, bin, i_valid, busy, frame_done,
           timeout_err, block_cnt}, '0);
    rst = 1'b1;
    exp_q.delete();
    fea_sched.delete();
    done_cnt = 0;
    tick(4);
    check("no frame_done after aborted frame", done_cnt, 0);
    check("idle after aborted frame", busy, 0);
  endtask

  initial begin
    stim_en   = 1'b0;
    hold_mode = 1'b1;
    prep_frame(N_BLOCKS, 1'b1, 1'b0);
    rst = 1'b0;
    tick(3);
    check("reset outputs",
          {s_ready, addr_fw, valid_fw, address, bin, i_valid, busy, frame_done,
           timeout_err, block_cnt}, '0);
    rst = 1'b1;
    tick(2);

    // Back-to-back cells, full block return
    run_frame(N_BLOCKS, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // 50% input bubbles
    run_frame(N_BLOCKS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // One block missing: drain timeout
    run_frame(N_BLOCKS - 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // Starts during RUN and in the frame_done cycle are ignored
    run_frame(N_BLOCKS, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    // Reset aborts a frame; the next frame restarts from cell 0
    reset_mid_frame();
    run_frame(N_BLOCKS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hog_cell_scheduler.md
Name: hog_cell_scheduler

Overview:
- Frame-level sequencer in front of hog_feature_gen.
- Accepts per-cell 9-bin histograms from the histogram stage over a valid/ready stream.
- Assigns each cell its linear raster address and issues the frame-start clear.
- Drives address/bin/i_valid into the feature generator, counts returned block features (o_valid) and signals frame completion or drain timeout.

Parameters:
- ADDR_W, 11, width of cell address and block counter
- BIN_W, 32, width of one bin (BIN_I+BIN_F)
- CELLS_X, 40, cells per row (must equal feature generator line depth)
- CELLS_Y, 30, cell rows per frame
- DRAIN_TO, 256, max idle cycles waiting for the next fea_valid in DRAIN
- MIN_GAP, 0, forced idle cycles between accepted cells (used only with HOG_SCHED_GAP_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  frame start pulse
- s_bin  in  9*BIN_W  cell histogram, bin0 in LSBs
- s_valid  in  1  s_bin valid
- s_ready  out  1  scheduler accepts s_bin
- addr_fw  out  ADDR_W  forward address to feature generator (0 during clear)
- valid_fw  out  1  forward-address strobe (clear when addr_fw==0)
- address  out  ADDR_W  linear cell index of bin
- bin  out  9*BIN_W  registered cell histogram
- i_valid  out  1  bin/address valid, one cycle per cell
- fea_valid  in  1  o_valid from feature generator, one pulse per block
- busy  out  1  high in CLEAR, RUN, DRAIN
- frame_done  out  1  one-cycle pulse at end of frame
- timeout_err  out  1  sticky; set on drain timeout, cleared by next accepted start
- block_cnt  out  ADDR_W  blocks received in current frame

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; all outputs 0, including bin, address, block_cnt and timeout_err. Reset mid-frame aborts the frame; no frame_done.
- States: IDLE, CLEAR, RUN, DRAIN.
- IDLE:
  - s_ready=0; fea_valid ignored.
  - start → CLEAR; block_cnt←0; timeout_err←0.
- CLEAR: one cycle.
  - addr_fw=0, valid_fw=1 (resets the feature generator's serial-to-parallel and line-buffer counters).
  - Next state RUN.
  - valid_fw is 0 in every other state.
- RUN:
  - s_ready=1.
  - On s_valid&s_ready (accept), next cycle: i_valid=1, address=cell_idx, bin=s_bin (1-cycle latency); cell_idx increments.
  - Without an accept: i_valid=0; bin/address hold.
  - cell_idx runs 0..CELLS_X*CELLS_Y-1 with no wrap inside a frame.
  - Accepting cell CELLS_X*CELLS_Y-1 → DRAIN, s_ready=0 from the next cycle.
- DRAIN:
  - Waits until block_cnt reaches (CELLS_X-1)*(CELLS_Y-1).
  - On reaching it: frame_done pulse, → IDLE.
  - Idle counter resets on each fea_valid. If it reaches DRAIN_TO: timeout_err←1, frame_done pulse, → IDLE.
- block_cnt:
  - Increments on fea_valid in CLEAR, RUN and DRAIN only.
  - Saturates at the all-ones value.
  - Holds its value in IDLE until the next start.
- start while busy is ignored. start in the same cycle as frame_done is ignored; a new start is needed in IDLE.
- fea_valid and frame-end in the same cycle: the count includes that pulse.
- s_ready is combinational from state (and the gap counter only).

Optional Feature:
- Macro HOG_SCHED_GAP_EN.
- Defined: after each accept, s_ready=0 for MIN_GAP cycles (gap counter), throttling the feature generator normalizer. With MIN_GAP=0 this behaves as undefined.
- Undefined: back-to-back accepts every cycle; MIN_GAP is ignored; no gap counter logic.

Test Plan:
- CELLS_X=4, CELLS_Y=3, s_valid held high, start pulse → valid_fw=1 with addr_fw=0 for exactly 1 cycle; 12 i_valid pulses with address 0..11 back-to-back; feature-gen model returns 6 fea_valid → frame_done single pulse; block_cnt=6; timeout_err=0.
- Random s_valid bubbles (50%) → address sequence still 0..11 with no gaps or duplicates; bin equals the accepted s_bin one cycle after each accept.
- Model returns only 5 fea_valid, DRAIN_TO=16 → frame_done 16 cycles after the last fea_valid; timeout_err=1; next start clears timeout_err.
- start pulsed during RUN and in the frame_done cycle → ignored: no extra valid_fw, address continues; state IDLE after frame_done.
- rst driven low at cell 5 → next cycle all outputs 0, state IDLE; new start restarts at address 0 with a clear cycle.
- HOG_SCHED_GAP_EN, MIN_GAP=2, s_valid held high → i_valid pulses every 3 cycles; 12 cells complete in 34 cycles after CLEAR.
